// File: rtl/trace_capture_ram_if.sv
// Bus bundle for trace_capture_ram: capture control, sample stream,
// status and ROM-shaped readback. The sample source and controller sit on
// the master side; the capture RAM sits on the slave side.
interface trace_capture_ram_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] trig_level;
  logic [ADDR_W:0]   cap_len;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              armed;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   cap_count;

  modport master (
    output arm, abort, trig_level, cap_len, sample_valid, sample_data, rd_addr,
    input  rd_data, armed, busy, done, cap_count
  );

  modport slave (
    input  arm, abort, trig_level, cap_len, sample_valid, sample_data, rd_addr,
    output rd_data, armed, busy, done, cap_count
  );
endinterface

// File: rtl/trace_capture_ram.sv
// Threshold-triggered trace recorder. Waits for a rising crossing of
// trig_level on the sample stream, then stores cap_len samples into an
// internal block RAM that is read back with the same address/data shape
// as the golden trace ROMs.
module trace_capture_ram #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) (
  input  logic clk,
  input  logic reset,
  trace_capture_ram_if.slave bus
);
  localparam int unsigned     DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_ZERO = '0;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   cap_count_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic              prev_below_reg;
  logic              armed_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [DATA_W-1:0] rd_data_reg;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   count_inc;
  logic              above;
  logic              trig_hit;
  logic              wr_en;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Length clamp, crossing detect and the single RAM write strobe
  always_comb begin
    len_clamped = bus.cap_len;
    if (bus.cap_len == CNT_ZERO || bus.cap_len > DEPTH_V)
      len_clamped = DEPTH_V;
    count_inc = cap_count_reg + CNT_ONE;
    above     = (bus.sample_data >= bus.trig_level);
    trig_hit  = (state_reg == ARMED) && bus.sample_valid && prev_below_reg && above;
    // abort (and reset) take priority, so the sample in that cycle is dropped
    wr_en     = !reset && !bus.abort &&
                (trig_hit || (state_reg == CAPTURE && bus.sample_valid));
  end

  // Capture FSM; status flags are registered alongside each state change
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      len_reg        <= DEPTH_V;
      cap_count_reg  <= '0;
      wr_ptr_reg     <= '0;
      prev_below_reg <= 1'b0;
      armed_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else if (bus.abort) begin
      // cap_count is kept so software can see how far the capture got
      state_reg <= IDLE;
      armed_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.arm) begin
            state_reg      <= ARMED;
            len_reg        <= len_clamped;
            cap_count_reg  <= '0;
            wr_ptr_reg     <= '0;
            prev_below_reg <= 1'b0;
            armed_reg      <= 1'b1;
            done_reg       <= 1'b0;
          end
        end
        ARMED: begin
          if (bus.sample_valid) begin
            prev_below_reg <= !above;
            if (prev_below_reg && above) begin
              // trigger sample itself lands at address 0
              cap_count_reg <= CNT_ONE;
              wr_ptr_reg    <= wr_ptr_reg + PTR_ONE;
              armed_reg     <= 1'b0;
              if (len_reg == CNT_ONE) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= CAPTURE;
                busy_reg  <= 1'b1;
              end
            end
          end
        end
        CAPTURE: begin
          if (bus.sample_valid) begin
            // a full-depth capture wraps the pointer only after the last write
            wr_ptr_reg    <= wr_ptr_reg + PTR_ONE;
            cap_count_reg <= count_inc;
            if (count_inc == len_reg) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM write port; the array is never reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= bus.sample_data;
  end

  // Registered read port; blanked while capturing to avoid read/write overlap
  always_ff @(posedge clk) begin
    if (reset || busy_reg)
      rd_data_reg <= '0;
    else
      rd_data_reg <= mem[bus.rd_addr];
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.armed     = armed_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.cap_count = cap_count_reg;
endmodule
